// File: rtl/icache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_assoc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_e;

   function automatic int clog2_i(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
interface icache_assoc_if
   import icache_assoc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int PC_BITS    = 5,
   parameter int LINE_WORDS = 4
);
   localparam int MADDR = PC_BITS - clog2_i(LINE_WORDS);

   logic [PC_BITS-1:0]         F_pc;
   logic                       F_flush;
   logic [XLEN-1:0]            F_inst;
   logic                       F_stall;
   logic                       F_mem_req;
   logic [MADDR-1:0]           F_mem_addr;
   logic [LINE_WORDS*XLEN-1:0] F_mem_inst;
   logic                       F_mem_valid;

   modport master (
      output F_pc, F_flush, F_mem_inst, F_mem_valid,
      input  F_inst, F_stall, F_mem_req, F_mem_addr
   );

   modport slave (
      input  F_pc, F_flush, F_mem_inst, F_mem_valid,
      output F_inst, F_stall, F_mem_req, F_mem_addr
   );

endinterface

// File: rtl/icache_victim_sel.sv
// Fill-way choice: lowest invalid way, else the set's round-robin pointer.
module icache_victim_sel #(
   parameter int WAYS = 2,
   parameter int WW   = 1
) (
   input  logic [WAYS-1:0] valid,
   input  logic [WW-1:0]   ptr,
   output logic [WW-1:0]   way,
   output logic            evict
);

   always_comb begin
      way   = ptr;
      evict = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) begin
            way   = WW'(w);
            evict = 1'b0;
         end
      end
   end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with zero-latency hits and one
// outstanding line fill; saturating hit/miss counters.
module icache_assoc
   import icache_assoc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int PC_BITS    = 5,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 2,
   parameter int WAYS       = 2,
   parameter int CNT_BITS   = 16
) (
   input  logic                clk,
   input  logic                rst,
   icache_assoc_if.slave       f,
   output logic [CNT_BITS-1:0] hit_cnt,
   output logic [CNT_BITS-1:0] miss_cnt
);

   localparam int OFF   = clog2_i(LINE_WORDS);
   localparam int IDX   = clog2_i(SETS);
   localparam int TAG   = PC_BITS - OFF - IDX;
   localparam int MADDR = PC_BITS - OFF;
   localparam int IDXW  = (IDX > 0) ? IDX : 1;
   localparam int WW    = (WAYS > 1) ? clog2_i(WAYS) : 1;

   logic [WAYS-1:0]            valid_q [SETS];
   logic [WW-1:0]              ptr_q   [SETS];
   logic [TAG-1:0]             tag_q   [SETS][WAYS];
   logic [LINE_WORDS*XLEN-1:0] data_q  [SETS][WAYS];

   icache_state_e    st_q;
   logic             abort_q;
   logic [MADDR-1:0] addr_q;
   logic [IDXW-1:0]  idx_q;

   logic [OFF-1:0]  off;
   logic [IDXW-1:0] idx;
   logic [TAG-1:0]  tag;
   logic            hit_any;
   logic            hit;
   logic            install;
   logic [XLEN-1:0] word;
   logic [WW-1:0]   vic_way;
   logic            evict;

   assign off = f.F_pc[OFF-1:0];
   assign tag = f.F_pc[PC_BITS-1:OFF+IDX];

   generate
      if (SETS > 1) begin : g_idx
         assign idx = f.F_pc[OFF+IDX-1:OFF];
      end else begin : g_noidx
         assign idx = '0;
      end
   endgenerate

   always_comb begin
      hit_any = 1'b0;
      word    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit_any = 1'b1;
            word    = data_q[idx][w][int'(off)*XLEN +: XLEN];
         end
      end
   end

   // A flush cycle never reports a hit, so it always stalls fetch.
   assign hit = rst && st_q == IDLE && !f.F_flush && hit_any;

   assign install = rst && st_q == FILL && f.F_mem_valid &&
                    !f.F_flush && !abort_q;

   assign f.F_inst     = hit ? word : '0;
   assign f.F_stall    = rst && !hit;
   assign f.F_mem_req  = rst && st_q == FILL;
   assign f.F_mem_addr = rst ? addr_q : '0;

   icache_victim_sel #(
      .WAYS (WAYS),
      .WW   (WW)
   ) u_vic (
      .valid (valid_q[idx_q]),
      .ptr   (ptr_q[idx_q]),
      .way   (vic_way),
      .evict (evict)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q     <= IDLE;
         abort_q  <= 1'b0;
         addr_q   <= '0;
         idx_q    <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         if (hit && hit_cnt != '1)
            hit_cnt <= hit_cnt + 1'b1;
         unique case (st_q)
            IDLE: begin
               if (f.F_flush) begin
                  for (int s = 0; s < SETS; s++)
                     valid_q[s] <= '0;
               end else if (!hit_any) begin
                  addr_q <= f.F_pc[PC_BITS-1:OFF];
                  idx_q  <= idx;
                  st_q   <= FILL;
                  if (miss_cnt != '1)
                     miss_cnt <= miss_cnt + 1'b1;
               end
            end
            FILL: begin
               // An aborted fill still waits for its return before IDLE.
               if (f.F_flush) begin
                  for (int s = 0; s < SETS; s++)
                     valid_q[s] <= '0;
                  abort_q <= !f.F_mem_valid;
                  if (f.F_mem_valid)
                     st_q <= IDLE;
               end else if (f.F_mem_valid) begin
                  st_q    <= IDLE;
                  abort_q <= 1'b0;
                  if (!abort_q) begin
                     valid_q[idx_q][vic_way] <= 1'b1;
                     if (evict && WAYS > 1)
                        ptr_q[idx_q] <= vic_way + 1'b1;
                  end
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (install) begin
         tag_q[idx_q][vic_way]  <= addr_q[MADDR-1:IDX];
         data_q[idx_q][vic_way] <= f.F_mem_inst;
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed table, flush/reset corner sequences and randomized accesses
// against a line-level cache model; ends with hit counter saturation.
module tb_icache_assoc;

   localparam int XLEN       = 32;
   localparam int PC_BITS    = 5;
   localparam int LINE_WORDS = 4;
   localparam int SETS       = 2;
   localparam int WAYS       = 2;
   localparam int CNT_BITS   = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [CNT_BITS-1:0] hit_cnt;
   logic [CNT_BITS-1:0] miss_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_lat = 2;
   int lat     = 0;

   always #5 clk = ~clk;

   icache_assoc_if #(
      .XLEN       (XLEN),
      .PC_BITS    (PC_BITS),
      .LINE_WORDS (LINE_WORDS)
   ) f ();

   icache_assoc #(
      .XLEN       (XLEN),
      .PC_BITS    (PC_BITS),
      .LINE_WORDS (LINE_WORDS),
      .SETS       (SETS),
      .WAYS       (WAYS),
      .CNT_BITS   (CNT_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .f        (f),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   typedef struct {
      logic [4:0]  pc;
      bit          miss;
      logic [2:0]  addr;
      logic [31:0] inst;
      int          hits;
      int          misses;
   } vec_t;

   vec_t vec [12];

   // line-level model: which tag sits in each set/way
   bit m_valid [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_ptr   [SETS];
   int m_hits;
   int m_misses;

   function automatic logic [31:0] mem_word(input int line, input int k);
      return 32'hC000_A000 | 32'(line << 16) | 32'(k);
   endfunction

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
      m_hits   = 0;
      m_misses = 0;
   endfunction

   function automatic void model_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
   endfunction

   // Every access ends with one hit cycle (the replay after a fill).
   function automatic bit model_access(input int pc);
      int s;
      int t;
      int v;
      s = (pc / LINE_WORDS) % SETS;
      t = pc / (LINE_WORDS * SETS);
      m_hits++;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) return 1'b0;
      m_misses++;
      v = -1;
      for (int w = 0; w < WAYS; w++)
         if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) begin
         v = m_ptr[s];
         m_ptr[s] = (m_ptr[s] + 1) % WAYS;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Advance one cycle; the backing memory answers mem_lat cycles into FILL.
   task automatic tick();
      @(posedge clk);
      #1;
      f.F_mem_valid = 1'b0;
      if (f.F_mem_req) begin
         lat++;
         if (lat >= mem_lat) begin
            f.F_mem_valid = 1'b1;
            for (int k = 0; k < LINE_WORDS; k++)
               f.F_mem_inst[k*XLEN +: XLEN] = mem_word(int'(f.F_mem_addr), k);
            lat = 0;
         end
      end else begin
         lat = 0;
      end
   endtask

   task automatic settle(output int stalls, output logic [31:0] inst,
                         output logic [2:0] addr);
      stalls = 0;
      addr   = '0;
      @(negedge clk);
      while (f.F_stall && stalls < 20) begin
         if (f.F_mem_req) addr = f.F_mem_addr;
         if (stalls == 0) check("inst_zero_on_miss", f.F_inst, 32'h0);
         stalls++;
         tick();
         @(negedge clk);
      end
      check("ready", 32'(f.F_stall), 32'h0);
      inst = f.F_inst;
      tick();
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      f.F_pc        = '0;
      f.F_flush     = 1'b0;
      f.F_mem_valid = 1'b0;
      f.F_mem_inst  = '0;
      tick();
      tick();
      @(negedge clk);
      check("rst_stall", 32'(f.F_stall), 32'h0);
      check("rst_req", 32'(f.F_mem_req), 32'h0);
      check("rst_addr", 32'(f.F_mem_addr), 32'h0);
      check("rst_inst", f.F_inst, 32'h0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
      check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
      tick();
      rst = 1'b1;
      model_reset();
   endtask

   task automatic model_cmp(input string name, input int pc);
      bit          exp_miss;
      int          st;
      logic [31:0] inst;
      logic [2:0]  addr;
      exp_miss = model_access(pc);
      f.F_pc   = 5'(pc);
      settle(st, inst, addr);
      check({name, "_miss"}, 32'(st > 0), 32'(exp_miss));
      check({name, "_stalls"}, 32'(st), exp_miss ? 32'(mem_lat + 1) : 32'h0);
      if (exp_miss) check({name, "_addr"}, 32'(addr), 32'(pc / LINE_WORDS));
      check({name, "_inst"}, inst, mem_word(pc / LINE_WORDS, pc % LINE_WORDS));
      check({name, "_hit_cnt"}, 32'(hit_cnt), 32'(sat(m_hits)));
      check({name, "_miss_cnt"}, 32'(miss_cnt), 32'(sat(m_misses)));
   endtask

   initial begin
      int          st;
      logic [31:0] inst;
      logic [2:0]  addr;

      vec[0]  = '{5'd0,  1'b1, 3'd0, 32'hC000_A000, 1,  1};
      vec[1]  = '{5'd1,  1'b0, 3'd0, 32'hC000_A001, 2,  1};
      vec[2]  = '{5'd2,  1'b0, 3'd0, 32'hC000_A002, 3,  1};
      vec[3]  = '{5'd3,  1'b0, 3'd0, 32'hC000_A003, 4,  1};
      vec[4]  = '{5'd8,  1'b1, 3'd2, 32'hC002_A000, 5,  2};
      vec[5]  = '{5'd16, 1'b1, 3'd4, 32'hC004_A000, 6,  3};
      vec[6]  = '{5'd0,  1'b1, 3'd0, 32'hC000_A000, 7,  4};
      vec[7]  = '{5'd8,  1'b1, 3'd2, 32'hC002_A000, 8,  5};
      vec[8]  = '{5'd0,  1'b0, 3'd0, 32'hC000_A000, 9,  5};
      vec[9]  = '{5'd4,  1'b1, 3'd1, 32'hC001_A000, 10, 6};
      vec[10] = '{5'd21, 1'b1, 3'd5, 32'hC005_A001, 11, 7};
      vec[11] = '{5'd7,  1'b0, 3'd1, 32'hC001_A003, 12, 7};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         f.F_pc = vec[i].pc;
         settle(st, inst, addr);
         check($sformatf("v%0d_miss", i), 32'(st > 0), 32'(vec[i].miss));
         check($sformatf("v%0d_stalls", i), 32'(st),
               vec[i].miss ? 32'd3 : 32'd0);
         if (vec[i].miss)
            check($sformatf("v%0d_addr", i), 32'(addr), 32'(vec[i].addr));
         check($sformatf("v%0d_inst", i), inst, vec[i].inst);
         check($sformatf("v%0d_hit_cnt", i), 32'(hit_cnt), 32'(vec[i].hits));
         check($sformatf("v%0d_miss_cnt", i), 32'(miss_cnt),
               32'(vec[i].misses));
      end

      // flush in IDLE while the fetch address would hit
      f.F_pc    = 5'd1;
      f.F_flush = 1'b1;
      @(negedge clk);
      check("idle_flush_stall", 32'(f.F_stall), 32'h1);
      check("idle_flush_inst", f.F_inst, 32'h0);
      tick();
      f.F_flush = 1'b0;
      check("idle_flush_hit_cnt", 32'(hit_cnt), 32'd12);
      settle(st, inst, addr);
      check("after_flush_stalls", 32'(st), 32'd3);
      check("after_flush_inst", inst, 32'hC000_A001);
      check("after_flush_miss_cnt", 32'(miss_cnt), 32'd8);

      // flush one cycle into FILL
      do_reset();
      f.F_pc = 5'd0;
      tick();
      f.F_flush = 1'b1;
      @(negedge clk);
      check("fill_flush_req", 32'(f.F_mem_req), 32'h1);
      check("fill_flush_addr", 32'(f.F_mem_addr), 32'h0);
      tick();
      f.F_flush = 1'b0;
      tick();
      m_misses++;
      model_cmp("fill_flush_refetch", 0);

      // flush in the same cycle as the returning line
      do_reset();
      f.F_pc = 5'd0;
      tick();
      tick();
      f.F_flush = 1'b1;
      @(negedge clk);
      check("flush_valid_req", 32'(f.F_mem_req), 32'h1);
      tick();
      f.F_flush = 1'b0;
      m_misses++;
      model_cmp("flush_valid_refetch", 0);

      // reset during FILL, stray line return afterwards
      do_reset();
      f.F_pc = 5'd0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_fill_stall", 32'(f.F_stall), 32'h0);
      check("rst_fill_req", 32'(f.F_mem_req), 32'h0);
      check("rst_fill_addr", 32'(f.F_mem_addr), 32'h0);
      tick();
      rst           = 1'b1;
      f.F_mem_valid = 1'b1;
      for (int k = 0; k < LINE_WORDS; k++)
         f.F_mem_inst[k*XLEN +: XLEN] = mem_word(0, k);
      @(negedge clk);
      check("stray_valid_stall", 32'(f.F_stall), 32'h1);
      check("stray_valid_hit_cnt", 32'(hit_cnt), 32'h0);
      check("stray_valid_miss_cnt", 32'(miss_cnt), 32'h0);
      tick();
      model_reset();
      void'(model_access(0));
      settle(st, inst, addr);
      check("rst_fill_stalls", 32'(st), 32'(mem_lat));
      check("rst_fill_addr2", 32'(addr), 32'h0);
      check("rst_fill_inst", inst, mem_word(0, 0));
      check("rst_fill_hit_cnt", 32'(hit_cnt), 32'(m_hits));
      check("rst_fill_miss_cnt", 32'(miss_cnt), 32'(m_misses));

      // randomized accesses, latencies and occasional flushes
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            f.F_pc    = 5'($urandom_range(0, 31));
            f.F_flush = 1'b1;
            @(negedge clk);
            check("rnd_flush_stall", 32'(f.F_stall), 32'h1);
            check("rnd_flush_inst", f.F_inst, 32'h0);
            tick();
            f.F_flush = 1'b0;
            model_flush();
         end
         mem_lat = $urandom_range(1, 4);
         model_cmp($sformatf("rnd%0d", i), $urandom_range(0, 31));
      end

      // hit counter saturation
      mem_lat = 2;
      model_cmp("sat_prime", 9);
      f.F_pc = 5'd9;
      @(negedge clk);
      check("sat_no_stall", 32'(f.F_stall), 32'h0);
      for (int i = 0; i < 65536; i++) tick();
      m_hits += 65536;
      check("sat_hit_cnt", 32'(hit_cnt), 32'(sat(m_hits)));
      check("sat_miss_cnt", 32'(miss_cnt), 32'(sat(m_misses)));
      @(negedge clk);
      check("sat_inst", f.F_inst, mem_word(2, 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001: Parameter XLEN, default 32, instruction width in bits.
REQ-002: Parameter PC_BITS, default 5, word-addressed PC width.
REQ-003: Parameter LINE_WORDS, default 4, words per line, power of two and at least 2.
REQ-004: Parameter SETS, default 2, number of sets, power of two and at least 1.
REQ-005: Parameter WAYS, default 2, associativity, power of two and at least 1.
REQ-006: Parameter CNT_BITS, default 16, width of each performance counter.
REQ-007: Derived widths: OFF=log2(LINE_WORDS), IDX=log2(SETS), TAG=PC_BITS-OFF-IDX (at least 1), MADDR=PC_BITS-OFF.
REQ-008: Single clock `clk`; reset `rst` is synchronous and active-low.
REQ-009: Port list (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, synchronous active-low reset.
  - F_pc, in, PC_BITS, fetch address.
  - F_flush, in, 1, single-cycle pulse; invalidates all lines.
  - F_inst, out, XLEN, instruction at F_pc when hit, else 0.
  - F_stall, out, 1, fetch must hold F_pc.
  - F_mem_req, out, 1, line-read request.
  - F_mem_addr, out, MADDR, line address, equal to F_pc[PC_BITS-1:OFF] latched at miss.
  - F_mem_inst, in, LINE_WORDS*XLEN, returned line; word k occupies bits [k*XLEN +: XLEN].
  - F_mem_valid, in, 1, one-cycle pulse; line valid.
  - hit_cnt, out, CNT_BITS, saturating hit count.
  - miss_cnt, out, CNT_BITS, saturating miss count.

Function
REQ-010: F_pc decomposes as offset=[OFF-1:0], index=[OFF+IDX-1:OFF], tag=upper TAG bits; when SETS=1, index is empty and set 0 is used.
REQ-011: Storage per set and way: valid bit, tag, LINE_WORDS data words. Each set also holds a round-robin victim pointer of log2(WAYS) bits.
REQ-012: FSM has two states, IDLE and FILL.
REQ-013: In IDLE, a hit means some way of the indexed set is valid with a matching tag.
REQ-014: On a hit in IDLE, the block SHALL assert F_inst = word[offset] and F_stall=0 combinationally, in the same cycle (zero-latency hit).
REQ-015: On a miss in IDLE, the block SHALL assert F_stall=1 combinationally and latch the line address and index, and SHALL move to FILL at the next edge; miss_cnt increments once.
REQ-016: In FILL, the block SHALL hold F_mem_req=1 and F_mem_addr stable and keep F_stall=1 until F_mem_valid is sampled high.
REQ-017: On F_mem_valid in FILL, the block SHALL install the line into the victim way, set valid, write the tag, and return to IDLE. The installed line is visible to lookup from the next cycle, so the minimum miss penalty is memory latency plus 1 cycle.
REQ-018: Victim selection SHALL pick the lowest-numbered invalid way; if none is invalid, it SHALL use the set's round-robin pointer and then increment that pointer (modulo WAYS). The pointer changes only on an eviction.
REQ-019: F_mem_valid sampled while in IDLE SHALL be ignored.
REQ-020: If F_pc changes during FILL, the block SHALL still install the latched line; lookup of the new F_pc occurs in IDLE.
REQ-021: F_flush in IDLE SHALL clear all valid bits at the edge; in the flush cycle F_stall=1 and no hit is reported.
REQ-022: F_flush in FILL SHALL clear all valid bits and set an abort flag. The pending return SHALL be consumed without install, and the FSM then returns to IDLE.
REQ-023: F_flush together with F_mem_valid in the same cycle: flush wins, and no install occurs.
REQ-024: hit_cnt SHALL increment on each IDLE cycle with a hit and no flush. Both counters SHALL saturate at all-ones.
REQ-025: F_inst SHALL be 0 whenever there is no hit.

Reset
REQ-026: While rst=0 at a clk edge, the block SHALL set: all valid bits 0, victim pointers 0, FSM IDLE, abort 0, and both counters 0. Tag and data arrays are not reset.
REQ-027: While rst=0, the block SHALL force F_stall=0, F_mem_req=0, F_mem_addr=0 and F_inst=0.
REQ-028: Reset during FILL SHALL abandon the fill; a subsequent F_mem_valid is ignored.

Structure
REQ-029: A shared package SHALL hold the icache FSM state enumeration and the log2 width-derivation function.
REQ-030: One sub-module, icache_victim_sel, SHALL compute the victim way from the valid vector and the pointer; it is purely combinational.

Verification (defaults; backing-memory latency 2)
REQ-031: Cold miss, F_pc=0 after reset -> F_stall=1, F_mem_req=1, F_mem_addr=0 until valid; the cycle after F_mem_valid, F_inst=word0 and F_stall=0; miss_cnt=1.
REQ-032: F_pc=1,2,3 after line 0 is filled -> hits with no stall, returning words 1..3; hit_cnt increments by 3.
REQ-033: F_pc=0, 8, 16 in sequence (all set 0) -> three misses; the fill for 16 evicts way 0 (tag 0), so F_pc=0 then misses again and evicts way 1 (tag 1).
REQ-034: F_flush one cycle after a miss begins (during FILL) -> the returned line is not installed, and F_pc=0 misses again with F_mem_addr=0.
REQ-035: rst low during FILL, with F_mem_valid arriving afterwards -> no install; F_pc=0 misses after reset; counters are 0.
REQ-036: Force both counters to all-ones and keep hitting -> hit_cnt stays at 0xFFFF.
